// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D-cache memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way request picker; ARB_RR_EN selects round-robin,
// otherwise fixed priority with the D-cache winning ties.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
`ifdef ARB_RR_EN
    input  logic       last_d_i,
`endif
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = GNT_NONE;
        if (i_req_i && d_req_i) begin
`ifdef ARB_RR_EN
            grant_o = last_d_i ? GNT_I : GNT_D;
`else
            grant_o = GNT_D;
`endif
        end else if (d_req_i) begin
            grant_o = GNT_D;
        end else if (i_req_i) begin
            grant_o = GNT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory port between I-cache and D-cache; one transaction
// at a time. Define ARB_RR_EN for round-robin arbitration on ties.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant
);

    state_e     state_q, state_d;
    mem_req_t   req_q, req_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] pick_c;
    mem_req_t   i_req_c, d_req_c;

`ifdef ARB_RR_EN
    logic last_d_q, last_d_d;
`endif

    mem_arb_pick u_pick (
        .i_req_i  (i_mem_read | i_mem_write),
        .d_req_i  (d_mem_read | d_mem_write),
`ifdef ARB_RR_EN
        .last_d_i (last_d_q),
`endif
        .grant_o  (pick_c)
    );

    // An illegal read+write request is forwarded as a write only.
    always_comb begin
        i_req_c = '{read: i_mem_read & ~i_mem_write, write: i_mem_write,
                    addr: i_mem_addr, wdata: i_mem_wdata};
        d_req_c = '{read: d_mem_read & ~d_mem_write, write: d_mem_write,
                    addr: d_mem_addr, wdata: d_mem_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pick_c == GNT_I) begin
                    state_d = BUSY_I;
                end else if (pick_c == GNT_D) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register next values: load winner in IDLE, clear on completion.
    always_comb begin
        req_d   = req_q;
        grant_d = grant_q;
`ifdef ARB_RR_EN
        last_d_d = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                grant_d = pick_c;
                req_d   = '0;
                if (pick_c == GNT_I) begin
                    req_d = i_req_c;
`ifdef ARB_RR_EN
                    last_d_d = 1'b0;
`endif
                end else if (pick_c == GNT_D) begin
                    req_d = d_req_c;
`ifdef ARB_RR_EN
                    last_d_d = 1'b1;
`endif
                end
            end
            default: begin
                if (mem_ready) begin
                    req_d   = '0;
                    grant_d = GNT_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            grant_q <= GNT_NONE;
`ifdef ARB_RR_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            req_q   <= req_d;
            grant_q <= grant_d;
`ifdef ARB_RR_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    assign mem_read  = req_q.read;
    assign mem_write = req_q.write;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign grant     = grant_q;

    // Completion and read data reach only the port that owns the memory.
    assign i_mem_ready = (state_q == BUSY_I) & mem_ready;
    assign d_mem_ready = (state_q == BUSY_D) & mem_ready;
    assign i_mem_rdata = (state_q == BUSY_I) ? mem_rdata : '0;
    assign d_mem_rdata = (state_q == BUSY_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset-abort sequence and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_mem_read, i_mem_write, d_mem_read, d_mem_write;
    logic [ADDR_W-1:0] i_mem_addr, d_mem_addr, mem_addr;
    logic [DATA_W-1:0] i_mem_wdata, d_mem_wdata, mem_wdata;
    logic [DATA_W-1:0] i_mem_rdata, d_mem_rdata, mem_rdata;
    logic              i_mem_ready, d_mem_ready, mem_read, mem_write, mem_ready;
    logic [1:0]        grant;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    localparam logic [ADDR_W-1:0] I_ADDR  = 28'h0000010;
    localparam logic [ADDR_W-1:0] D_ADDR  = 28'h1234567;
    localparam logic [DATA_W-1:0] I_WDATA = {4{32'h0F0F1234}};
    localparam logic [DATA_W-1:0] D_WDATA = {4{32'h55555555}};
    localparam logic [DATA_W-1:0] AAAA    = {4{32'hAAAAAAAA}};

`ifdef ARB_RR_EN
    localparam logic WI = 1'b1;   // after a D grant, a tie goes to I
`else
    localparam logic WI = 1'b0;   // ties always go to D
`endif
    localparam logic [1:0] GW = WI ? 2'b01 : 2'b10;
    localparam logic [1:0] GL = WI ? 2'b10 : 2'b01;

    typedef struct {
        logic ir, iw, dr, dw, mr;
        logic [1:0] e_gnt;
        logic e_rd, e_wr, e_irdy, e_drdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic ir, logic iw, logic dr, logic dw, logic mr,
                               logic [1:0] g, logic rd, logic wr, logic irdy, logic drdy);
        vec_t t;
        t.ir = ir; t.iw = iw; t.dr = dr; t.dw = dw; t.mr = mr;
        t.e_gnt = g; t.e_rd = rd; t.e_wr = wr; t.e_irdy = irdy; t.e_drdy = drdy;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: who owns the port and what request it holds.
    int                m_owner;   // 0 none, 1 I, 2 D
    logic              m_rd, m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
`ifdef ARB_RR_EN
    logic              m_last_d;
`endif

    task automatic model_reset();
        m_owner = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
`ifdef ARB_RR_EN
        m_last_d = 1'b0;
`endif
    endtask

    task automatic model_edge();
        int win;
        logic ai, ad;
        if (m_owner == 0) begin
            ai = i_mem_read | i_mem_write;
            ad = d_mem_read | d_mem_write;
            if (ai && ad) begin
`ifdef ARB_RR_EN
                win = m_last_d ? 1 : 2;
`else
                win = 2;
`endif
            end else begin
                win = ad ? 2 : (ai ? 1 : 0);
            end
            if (win == 1) begin
                m_rd = i_mem_read & ~i_mem_write; m_wr = i_mem_write;
                m_addr = i_mem_addr; m_wdata = i_mem_wdata;
            end else if (win == 2) begin
                m_rd = d_mem_read & ~d_mem_write; m_wr = d_mem_write;
                m_addr = d_mem_addr; m_wdata = d_mem_wdata;
            end
            m_owner = win;
`ifdef ARB_RR_EN
            if (win != 0) m_last_d = (win == 2);
`endif
        end else if (mem_ready) begin
            model_reset_txn();
        end
    endtask

    task automatic model_reset_txn();
        m_owner = 0; m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    endtask

    initial begin
        logic [1:0] eg;
        logic       ia, da;
        logic       gi, gd;
        int         k;

        rst_n = 1'b0;
        i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 0;
        i_mem_addr = I_ADDR; d_mem_addr = D_ADDR;
        i_mem_wdata = I_WDATA; d_mem_wdata = D_WDATA;
        mem_rdata = '0; mem_ready = 0;

        repeat (2) @(negedge clk);
        chk("reset grant", 128'(grant), 128'(2'b00));
        chk("reset mem_read", 128'(mem_read), 128'(1'b0));
        chk("reset mem_write", 128'(mem_write), 128'(1'b0));
        chk("reset mem_addr", 128'(mem_addr), 128'(0));
        chk("reset mem_wdata", 128'(mem_wdata), 128'(0));
        rst_n = 1'b1;

        // Rows: inputs for this cycle, outputs expected before the next edge.
        tbl.push_back(v(0,0,0,0,0, 2'b00, 0,0,0,0));
        tbl.push_back(v(1,0,0,0,0, 2'b00, 0,0,0,0));
        tbl.push_back(v(1,0,0,0,0, 2'b01, 1,0,0,0));
        tbl.push_back(v(1,0,0,0,0, 2'b01, 1,0,0,0));
        tbl.push_back(v(1,0,0,0,0, 2'b01, 1,0,0,0));
        tbl.push_back(v(1,0,0,0,0, 2'b01, 1,0,0,0));
        tbl.push_back(v(1,0,0,0,1, 2'b01, 1,0,1,0));
        tbl.push_back(v(0,0,0,0,0, 2'b00, 0,0,0,0));
        tbl.push_back(v(0,0,0,0,1, 2'b00, 0,0,0,0));
        tbl.push_back(v(0,0,0,1,0, 2'b00, 0,0,0,0));
        tbl.push_back(v(0,0,0,1,0, 2'b10, 0,1,0,0));
        tbl.push_back(v(1,0,0,1,0, 2'b10, 0,1,0,0));
        tbl.push_back(v(1,0,0,1,1, 2'b10, 0,1,0,1));
        tbl.push_back(v(1,0,1,0,0, 2'b00, 0,0,0,0));
        tbl.push_back(v(1,0,1,0,0, GW,    1,0,0,0));
        tbl.push_back(v(1,0,1,0,1, GW,    1,0,WI,!WI));
        tbl.push_back(v(!WI,0,WI,0,0, 2'b00, 0,0,0,0));
        tbl.push_back(v(!WI,0,WI,0,0, GL,    1,0,0,0));
        tbl.push_back(v(!WI,0,WI,0,1, GL,    1,0,!WI,WI));
        tbl.push_back(v(0,0,0,0,0, 2'b00, 0,0,0,0));
        tbl.push_back(v(1,1,0,0,0, 2'b00, 0,0,0,0));
        tbl.push_back(v(1,1,0,0,0, 2'b01, 0,1,0,0));
        tbl.push_back(v(1,1,0,0,1, 2'b01, 0,1,1,0));
        tbl.push_back(v(0,0,0,0,0, 2'b00, 0,0,0,0));

        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            i_mem_read = tbl[r].ir; i_mem_write = tbl[r].iw;
            d_mem_read = tbl[r].dr; d_mem_write = tbl[r].dw;
            mem_ready = tbl[r].mr;
            mem_rdata = (r == 6) ? AAAA : {$urandom, $urandom, $urandom, $urandom};
            #1;
            eg = tbl[r].e_gnt;
            chk($sformatf("row%0d grant", r), 128'(grant), 128'(eg));
            chk($sformatf("row%0d mem_read", r), 128'(mem_read), 128'(tbl[r].e_rd));
            chk($sformatf("row%0d mem_write", r), 128'(mem_write), 128'(tbl[r].e_wr));
            chk($sformatf("row%0d mem_addr", r), 128'(mem_addr),
                128'(eg == 2'b01 ? I_ADDR : (eg == 2'b10 ? D_ADDR : 28'h0)));
            chk($sformatf("row%0d mem_wdata", r), mem_wdata,
                eg == 2'b01 ? I_WDATA : (eg == 2'b10 ? D_WDATA : 128'h0));
            chk($sformatf("row%0d i_ready", r), 128'(i_mem_ready), 128'(tbl[r].e_irdy));
            chk($sformatf("row%0d d_ready", r), 128'(d_mem_ready), 128'(tbl[r].e_drdy));
            if (tbl[r].e_irdy) chk($sformatf("row%0d i_rdata", r), i_mem_rdata, mem_rdata);
            else if (eg != 2'b01) chk($sformatf("row%0d i_rdata idle", r), i_mem_rdata, 128'h0);
            if (tbl[r].e_drdy) chk($sformatf("row%0d d_rdata", r), d_mem_rdata, mem_rdata);
            else if (eg != 2'b10) chk($sformatf("row%0d d_rdata idle", r), d_mem_rdata, 128'h0);
        end

        // Reset in the middle of a D write abandons it; later ready is dropped.
        @(negedge clk);
        i_mem_read = 0; i_mem_write = 0; d_mem_read = 0; d_mem_write = 1; mem_ready = 0;
        @(negedge clk);
        #1;
        chk("abort busy grant", 128'(grant), 128'(2'b10));
        chk("abort busy mem_write", 128'(mem_write), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("abort mem_write", 128'(mem_write), 128'(1'b0));
        chk("abort grant", 128'(grant), 128'(2'b00));
        chk("abort mem_addr", 128'(mem_addr), 128'(0));
        @(negedge clk);
        d_mem_write = 0; rst_n = 1'b1; mem_ready = 1; mem_rdata = AAAA;
        #1;
        chk("abort d_ready", 128'(d_mem_ready), 128'(1'b0));
        chk("abort i_ready", 128'(i_mem_ready), 128'(1'b0));
        chk("abort d_rdata", d_mem_rdata, 128'h0);
        @(negedge clk);
        mem_ready = 0;
        #1;
        chk("abort idle grant", 128'(grant), 128'(2'b00));

        // Randomized traffic: caches hold requests until they see their ready.
        model_reset();
        ia = 0; da = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!ia) begin
                i_mem_read = 0; i_mem_write = 0;
                if ($urandom_range(0, 2) == 0) begin
                    ia = 1; k = $urandom_range(0, 9);
                    i_mem_read = (k < 5) || (k == 9); i_mem_write = (k >= 5);
                    i_mem_addr = ADDR_W'($urandom);
                    i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            if (!da) begin
                d_mem_read = 0; d_mem_write = 0;
                if ($urandom_range(0, 2) == 0) begin
                    da = 1; k = $urandom_range(0, 9);
                    d_mem_read = (k < 5) || (k == 9); d_mem_write = (k >= 5);
                    d_mem_addr = ADDR_W'($urandom);
                    d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            eg = (m_owner == 1) ? 2'b01 : ((m_owner == 2) ? 2'b10 : 2'b00);
            gi = (m_owner == 1) && mem_ready;
            gd = (m_owner == 2) && mem_ready;
            chk($sformatf("rnd%0d grant", c), 128'(grant), 128'(eg));
            chk($sformatf("rnd%0d mem_read", c), 128'(mem_read), 128'(m_rd));
            chk($sformatf("rnd%0d mem_write", c), 128'(mem_write), 128'(m_wr));
            chk($sformatf("rnd%0d mem_addr", c), 128'(mem_addr), 128'(m_addr));
            chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, m_wdata);
            chk($sformatf("rnd%0d i_ready", c), 128'(i_mem_ready), 128'(gi));
            chk($sformatf("rnd%0d d_ready", c), 128'(d_mem_ready), 128'(gd));
            chk($sformatf("rnd%0d i_rdata", c), i_mem_rdata,
                gi ? mem_rdata : ((m_owner == 1) ? i_mem_rdata : 128'h0));
            chk($sformatf("rnd%0d d_rdata", c), d_mem_rdata,
                gd ? mem_rdata : ((m_owner == 2) ? d_mem_rdata : 128'h0));
            @(posedge clk);
            model_edge();
            if (gi) ia = 0;
            if (gd) da = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
